// File: rtl/seq_mul_shift_add.sv
// Radix-2 shift-and-add sequential multiplier with signed/unsigned mode,
// a full-width product, optional early termination, start/ready/done handshake and abort.
module seq_mul_shift_add #(
  parameter int WIDTH      = 16,
  parameter int EARLY_TERM = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 abort,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic              neg;
  logic [IW-1:0]     iter;
  logic              accept;
  logic              term;

  // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] sv;
    sv = signed'(v);
    if (sgn && (sv < 0)) return unsigned'(-sv);
    return v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic n);
    return n ? (-v) : v;
  endfunction

  assign ready  = (state == IDLE);
  assign accept = ready && start && !abort;
  assign term   = (EARLY_TERM != 0) ? ((mplier == '0) || (mcand == '0))
                                    : (iter == IW'(WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: if (abort || term) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Abort takes priority over termination, so a cancelled operation never pulses done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      iter    <= '0;
    end else begin
      done <= 1'b0;
      busy <= (state_next == CALC);
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
        mplier <= magnitude(b, signed_mode);
        acc    <= '0;
        iter   <= '0;
        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if ((state == CALC) && !abort) begin
        if (term) begin
          product <= apply_sign(acc, neg);
          done    <= 1'b1;
        end else begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          iter   <= iter + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Directed bench for seq_mul_shift_add: vector table over an early-terminating and a
// fixed-latency instance, plus hand-written handshake, abort and async-reset sequences.
module tb_seq_mul_shift_add;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start0 = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        abort = 1'b0;
  logic        ready1, busy1, done1, ready0, busy0, done0;
  logic [31:0] product1, product0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_mul_shift_add #(.WIDTH(16), .EARLY_TERM(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(signed_mode),
    .a(a), .b(b), .abort(abort), .ready(ready1), .busy(busy1), .done(done1),
    .product(product1)
  );

  seq_mul_shift_add #(.WIDTH(16), .EARLY_TERM(0)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .start(start0), .signed_mode(signed_mode),
    .a(a), .b(b), .abort(abort), .ready(ready0), .busy(busy0), .done(done0),
    .product(product0)
  );

  typedef struct {
    bit          fixed;
    bit          sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Caller positions time; returns 1ns after the acceptance edge with start dropped.
  task automatic launch(input bit sel, input bit sm, input logic [15:0] aa, input logic [15:0] bb);
    signed_mode = sm;
    a = aa;
    b = bb;
    if (sel) start0 = 1'b1;
    else     start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    signed_mode = 1'($urandom);
  endtask

  task automatic wait_done(input bit sel, input int n0, output int lat,
                           output logic [31:0] p, output bit hs_ok);
    int n;
    n = n0;
    hs_ok = 1'b1;
    while (!(sel ? done0 : done1) && n < 40) begin
      if (!(sel ? busy0 : busy1) || (sel ? ready0 : ready1)) hs_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if ((sel ? busy0 : busy1) || !(sel ? ready0 : ready1)) hs_ok = 1'b0;
    lat = n;
    p = sel ? product0 : product1;
  endtask

  initial begin
    int          lat;
    logic [31:0] p;
    bit          hs;
    bit          seen_done;

    vecs[0]  = '{1'b0, 1'b0, 16'h0003, 16'h0005, 32'h0000000F, 4};
    vecs[1]  = '{1'b0, 1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB, 4};
    vecs[2]  = '{1'b0, 1'b1, 16'h8000, 16'h8000, 32'h40000000, 17};
    vecs[3]  = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17};
    vecs[4]  = '{1'b1, 1'b0, 16'h0003, 16'h0005, 32'h0000000F, 17};
    vecs[5]  = '{1'b0, 1'b0, 16'h1234, 16'h0000, 32'h00000000, 1};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 16'hFFFF, 32'h00000000, 1};
    vecs[7]  = '{1'b0, 1'b1, 16'h0000, 16'hFFFB, 32'h00000000, 1};
    vecs[8]  = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 2};
    vecs[9]  = '{1'b0, 1'b1, 16'h7FFF, 16'h8000, 32'hC0008000, 17};
    vecs[10] = '{1'b0, 1'b0, 16'h00FF, 16'h0100, 32'h0000FF00, 10};
    vecs[11] = '{1'b1, 1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB, 17};

    // Reset state
    #12;
    check("reset_ready", {63'd0, ready1}, 64'd1);
    check("reset_busy", {63'd0, busy1}, 64'd0);
    check("reset_done", {63'd0, done1}, 64'd0);
    check("reset_product", {32'd0, product1}, 64'd0);
    check("reset_product_fixed", {32'd0, product0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      launch(vecs[i].fixed, vecs[i].sm, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].fixed, 0, lat, p, hs);
      check($sformatf("vec%0d_product", i), {32'd0, p}, {32'd0, vecs[i].p});
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_handshake", i), {63'd0, hs}, 64'd1);
    end

    // A start two cycles into an operation is ignored
    @(negedge clk);
    launch(1'b0, 1'b0, 16'h0003, 16'h0005);
    @(posedge clk); #1;
    @(negedge clk);
    start1 = 1'b1; a = 16'h0009; b = 16'h0009;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_done(1'b0, 2, lat, p, hs);
    check("ignored_start_product", {32'd0, p}, 64'h0F);
    check("ignored_start_latency", 64'(lat), 64'd4);

    // Start during the done cycle is accepted back-to-back
    launch(1'b0, 1'b0, 16'h0002, 16'h0002);
    check("b2b_product_held", {32'd0, product1}, 64'h0F);
    wait_done(1'b0, 0, lat, p, hs);
    check("b2b_product", {32'd0, p}, 64'h04);
    check("b2b_latency", 64'(lat), 64'd3);

    // Abort mid-CALC
    @(negedge clk);
    launch(1'b0, 1'b0, 16'h1234, 16'h5678);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ready", {63'd0, ready1}, 64'd1);
    check("abort_busy", {63'd0, busy1}, 64'd0);
    check("abort_product", {32'd0, product1}, 64'h04);
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done1) seen_done = 1'b1;
    end
    check("abort_no_done", {63'd0, seen_done}, 64'd0);

    // Abort has priority over start while idle
    @(negedge clk);
    abort = 1'b1; start1 = 1'b1; a = 16'h0003; b = 16'h0003;
    @(posedge clk); #1;
    check("idle_abort_ready", {63'd0, ready1}, 64'd1);
    check("idle_abort_busy", {63'd0, busy1}, 64'd0);
    abort = 1'b0; start1 = 1'b0;

    // Asynchronous reset mid-CALC
    @(negedge clk);
    launch(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("areset_busy", {63'd0, busy1}, 64'd0);
    check("areset_done", {63'd0, done1}, 64'd0);
    check("areset_product", {32'd0, product1}, 64'd0);
    check("areset_ready", {63'd0, ready1}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(1'b0, 1'b0, 16'd6, 16'd7);
    wait_done(1'b0, 0, lat, p, hs);
    check("post_reset_product", {32'd0, p}, 64'd42);
    check("post_reset_latency", 64'(lat), 64'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
